uart_rx_framed: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 `uart_receiver`. It adds a configurable data width, runtime parity and stop-bit modes, majority-vote sampling, false-start rejection, and per-word error flags (parity, framing, break). It also contains a buffered valid/ready output FIFO with overrun reporting. It sits between the pad-side `rx_i` line and the wishbone UART register block, and uses the same 16x-oversampling `baud_div_i` convention as the transmitter.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx_framed.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_T0 = 4'd7;
    localparam logic [3:0] SAMPLE_T1 = 4'd8;
    localparam logic [3:0] SAMPLE_T2 = 4'd9;
    localparam int MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        STOP2     = 3'd5,
        WAIT_HIGH = 3'd6
    } rx_state_t;

    // FIFO entry layout; data is sized for the widest legal frame.
    typedef struct packed {
        logic                  brk;
        logic                  ferr;
        logic                  perr;
        logic [MAX_DATA_W-1:0] data;
    } rx_entry_t;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return EVEN;
            2'b10:   return ODD;
            default: return NONE;
        endcase
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with occupancy output and registered overrun pulse.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push & (~full | do_pop);
    assign valid   = ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            overrun <= push & ~do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver: line synchroniser, 16x oversample tick generator, framing FSM
// with majority-vote sampling, and a receive FIFO with overrun reporting.
module uart_rx_framed #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [15:0]                   baud_div_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    input  logic                          rx_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          perr_o,
    output logic                          ferr_o,
    output logic                          brk_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o
);
    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_d;
    logic                   fall;
    logic [15:0]            clk_cnt;
    logic [15:0]            div_q;
    logic [TW-1:0]          tick_cnt;
    logic [TW-1:0]          tick_nxt;
    logic                   tick;
    logic                   decide;
    logic                   s7;
    logic                   s8;
    logic                   maj;
    rx_state_t              state;
    parity_t                par_q;
    logic                   stop2_q;
    logic [3:0]             bit_cnt;
    logic [DATA_W-1:0]      data_q;
    logic                   par_bit;
    logic                   ferr_q;
    logic                   brk_q;
    logic                   perr_now;
    logic                   brk_now;
    logic                   push;
    logic [DATA_W+2:0]      wr_word;
    logic [DATA_W+2:0]      rd_word;

    // Synchroniser resets high so reset release never looks like a start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= '1;
            rx_d <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_i};
            rx_d <= rx_s;
        end
    end

    assign rx_s     = sync[SYNC_STAGES-1];
    assign fall     = rx_d & ~rx_s;
    assign tick     = (clk_cnt >= div_q);
    assign tick_nxt = tick_cnt + 1'b1;
    assign decide   = tick && (tick_nxt == SAMPLE_T2);
    assign maj      = majority(s7, s8, rx_s);

    always_comb begin
        perr_now = 1'b0;
        case (par_q)
            EVEN:    perr_now = ^{data_q, par_bit};
            ODD:     perr_now = ~^{data_q, par_bit};
            default: perr_now = 1'b0;
        endcase
    end

    assign brk_now = (data_q == '0) && ((par_q == NONE) || !par_bit) && !maj;
    assign push    = decide && ((state == STOP2) || (state == STOP && !stop2_q));
    assign wr_word = {(state == STOP2) ? brk_q : brk_now,
                      (state == STOP2) ? (ferr_q | ~maj) : ~maj,
                      perr_now,
                      data_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            tick_cnt <= '0;
            div_q    <= '0;
            par_q    <= NONE;
            stop2_q  <= 1'b0;
            bit_cnt  <= '0;
            s7       <= 1'b0;
            s8       <= 1'b0;
            data_q   <= '0;
            par_bit  <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            if (tick) begin
                clk_cnt  <= '0;
                tick_cnt <= tick_nxt;
            end else begin
                clk_cnt  <= clk_cnt + 16'd1;
            end
            if (tick && tick_nxt == SAMPLE_T0) s7 <= rx_s;
            if (tick && tick_nxt == SAMPLE_T1) s8 <= rx_s;

            case (state)
                IDLE: begin
                    div_q <= baud_div_i;
                    // Restart the bit timebase so tick 0 sits on the falling edge.
                    if (fall) begin
                        clk_cnt  <= '0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: if (decide) begin
                    if (maj) begin
                        state <= IDLE;
                    end else begin
                        div_q   <= baud_div_i;
                        par_q   <= decode_parity(parity_i);
                        stop2_q <= stop2_i;
                        bit_cnt <= '0;
                        ferr_q  <= 1'b0;
                        brk_q   <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: if (decide) begin
                    data_q  <= {maj, data_q[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_W - 1))
                        state <= (par_q == NONE) ? STOP : PARITY;
                end
                PARITY: if (decide) begin
                    par_bit <= maj;
                    state   <= STOP;
                end
                STOP: if (decide) begin
                    ferr_q <= ~maj;
                    brk_q  <= brk_now;
                    if (stop2_q)  state <= STOP2;
                    else          state <= maj ? IDLE : WAIT_HIGH;
                end
                STOP2: if (decide) begin
                    state <= (ferr_q | ~maj) ? WAIT_HIGH : IDLE;
                end
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .wr_data (wr_word),
        .pop     (ready_i),
        .rd_data (rd_word),
        .valid   (valid_o),
        .level   (level_o),
        .overrun (overrun_o)
    );

    assign data_o = rd_word[DATA_W-1:0];
    assign perr_o = rd_word[DATA_W];
    assign ferr_o = rd_word[DATA_W+1];
    assign brk_o  = rd_word[DATA_W+2];

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomised bench for uart_rx_framed: frames are driven bit by bit and popped
// entries are compared against a frame-level reference model.
module tb_uart_rx_framed;

    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] baud     = 16'd3;
    logic [1:0]  par_mode = 2'b00;
    logic        stop2    = 1'b0;
    logic        line     = 1'b1;
    logic        sel      = 1'b0;
    logic        ready    = 1'b0;

    logic       rx8, rx9, rdy8, rdy9;
    logic [7:0] d8;
    logic [8:0] d9;
    logic       perr8, ferr8, brk8, valid8, ovr8;
    logic       perr9, ferr9, brk9, valid9, ovr9;
    logic [2:0] level8, level9;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_pop   = 0;
    int ovr_cyc = 0;
    int exp_ovr = 0;
    int mlevel  = 0;
    int snap_a, snap_b;
    logic [31:0] exp_q[$];
    logic [31:0] mon_got, mon_exp;

    assign rx8  = sel ? 1'b1 : line;
    assign rx9  = sel ? line : 1'b1;
    assign rdy8 = ready & ~sel;
    assign rdy9 = ready & sel;

    always #5 clk = ~clk;

    uart_rx_framed #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .baud_div_i(baud), .parity_i(par_mode),
        .stop2_i(stop2), .rx_i(rx8), .data_o(d8), .perr_o(perr8), .ferr_o(ferr8),
        .brk_o(brk8), .valid_o(valid8), .ready_i(rdy8), .level_o(level8),
        .overrun_o(ovr8)
    );

    uart_rx_framed #(.DATA_W(9), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut9 (
        .clk_i(clk), .rst_i(rst), .baud_div_i(baud), .parity_i(par_mode),
        .stop2_i(stop2), .rx_i(rx9), .data_o(d9), .perr_o(perr9), .ferr_o(ferr9),
        .brk_o(brk9), .valid_o(valid9), .ready_i(rdy9), .level_o(level9),
        .overrun_o(ovr9)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected entry {brk, ferr, perr, data} from the bits that appear on the wire.
    function automatic logic [31:0] model(input int nb, input logic [8:0] data,
                                          input logic [1:0] pm, input logic flip,
                                          input logic sb1, input logic s2, input logic sb2);
        logic [8:0] d;
        logic pen, pbit, perr, ferr, brk;
        d    = data & 9'((1 << nb) - 1);
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pbit = ((pm == 2'b10) ? ~(^d) : (^d)) ^ flip;
        perr = pen && ((pm == 2'b01) ? (^{d, pbit}) != 1'b0 : (^{d, pbit}) != 1'b1);
        ferr = !sb1 || (s2 && !sb2);
        brk  = (d == 9'd0) && (!pen || !pbit) && !sb1;
        return {20'd0, brk, ferr, perr, d};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        line = b;
        cyc(16 * (int'(baud) + 1));
    endtask

    task automatic send_frame(input int nb, input logic [8:0] data, input logic flip,
                              input logic sb1, input logic sb2, input int gap);
        logic [8:0]  d;
        logic        pen, pbit;
        logic [31:0] e;
        d    = data & 9'((1 << nb) - 1);
        pen  = (par_mode == 2'b01) || (par_mode == 2'b10);
        pbit = ((par_mode == 2'b10) ? ~(^d) : (^d)) ^ flip;
        e    = model(nb, d, par_mode, flip, sb1, stop2, sb2);
        if (!ready && mlevel == DEPTH) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(e);
            if (!ready) mlevel++;
        end
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(sb1);
        if (stop2) send_bit(sb2);
        line = 1'b1;
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    task automatic drain(input string tag);
        ready = 1'b1;
        cyc(12);
        mlevel = 0;
        chk({tag, "_queue"}, exp_q.size(), 0);
        chk({tag, "_level"}, sel ? level9 : level8, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sel ? (valid9 && ready) : (valid8 && ready)) begin
                mon_got = sel ? {20'd0, brk9, ferr9, perr9, d9}
                              : {20'd0, brk8, ferr8, perr8, 1'b0, d8};
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_pop++;
                chk("pop_entry", mon_got, mon_exp);
            end
            if (ovr8 || ovr9) ovr_cyc++;
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("rst_valid", valid8, 0);
        chk("rst_level", level8, 0);
        chk("rst_overrun", ovr8, 0);
        chk("rst_data", d8, 0);
        chk("rst_flags", {brk8, ferr8, perr8}, 0);
        rst = 1'b0;
        cyc(5);
        chk("idle_valid", valid8, 0);

        // 8N1 at 115200-equivalent divisor, back-to-back frames
        baud = 16'd26;
        ready = 1'b1;
        snap_a = n_pop;
        send_frame(8, 9'h0A5, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8, 9'h03C, 1'b0, 1'b1, 1'b1, 1);
        cyc(10);
        chk("b2b_pops", n_pop - snap_a, 2);
        chk("b2b_queue", exp_q.size(), 0);
        chk("b2b_no_overrun", ovr_cyc, 0);

        // 8E1 parity error then clean parity
        baud = 16'd3;
        par_mode = 2'b01;
        send_frame(8, 9'h055, 1'b1, 1'b1, 1'b1, 1);
        send_frame(8, 9'h055, 1'b0, 1'b1, 1'b1, 1);
        cyc(10);
        chk("parity_queue", exp_q.size(), 0);

        // Framing error, then a long break held low
        par_mode = 2'b00;
        ready = 1'b0;
        send_frame(8, 9'h012, 1'b0, 1'b0, 1'b1, 1);
        chk("ferr_level", level8, 1);
        exp_q.push_back(model(8, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        mlevel++;
        line = 1'b0;
        cyc(30 * 64);
        chk("break_level_low", level8, 2);
        line = 1'b1;
        cyc(2 * 64);
        chk("break_level_high", level8, 2);
        drain("break");

        // Short glitch must not start a frame
        ready = 1'b0;
        line = 1'b0;
        cyc(5);
        line = 1'b1;
        cyc(3 * 64);
        chk("glitch_level", level8, 0);
        chk("glitch_valid", valid8, 0);
        send_frame(8, 9'h0C3, 1'b0, 1'b1, 1'b1, 1);
        chk("post_glitch_level", level8, 1);
        drain("glitch");

        // Randomised frames across divisors, parity and stop modes
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            baud = 16'($urandom_range(0, 4));
            par_mode = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            send_frame(8, (k == 4) ? 9'h000 : 9'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0, 1);
        end
        cyc(10);
        chk("rand_queue", exp_q.size(), 0);

        // Overrun with a 4-deep FIFO and no consumer
        baud = 16'd3;
        par_mode = 2'b00;
        stop2 = 1'b0;
        ready = 1'b0;
        mlevel = 0;
        snap_a = ovr_cyc;
        snap_b = exp_ovr;
        for (int k = 1; k <= 6; k++) send_frame(8, 9'(k), 1'b0, 1'b1, 1'b1, 1);
        chk("ovr_level", level8, 4);
        chk("ovr_pulses", ovr_cyc - snap_a, exp_ovr - snap_b);
        chk("ovr_expected", exp_ovr - snap_b, 2);
        drain("ovr");

        // Asynchronous reset mid-frame with two entries held
        ready = 1'b0;
        send_frame(8, 9'h011, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8, 9'h022, 1'b0, 1'b1, 1'b1, 1);
        chk("pre_rst_level", level8, 2);
        line = 1'b0;
        cyc(3 * 64);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", valid8, 0);
        chk("async_rst_level", level8, 0);
        exp_q.delete();
        mlevel = 0;
        line = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(64);
        ready = 1'b1;
        snap_a = n_pop;
        send_frame(8, 9'h05A, 1'b0, 1'b1, 1'b1, 1);
        cyc(10);
        chk("post_rst_pops", n_pop - snap_a, 1);
        chk("post_rst_queue", exp_q.size(), 0);

        // 9-bit data, odd parity, two stop bits
        sel = 1'b1;
        par_mode = 2'b10;
        stop2 = 1'b1;
        send_frame(9, 9'h1A5, 1'b0, 1'b1, 1'b1, 1);
        for (int k = 0; k < 2; k++)
            send_frame(9, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                       1'b1, $urandom_range(0, 1) != 0, 1);
        cyc(10);
        chk("w9_queue", exp_q.size(), 0);
        chk("w9_level", level9, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
